alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- sequences one ALU operation at a time against an external ALU.
// A request reads its operands from a small register file. The controller drives
// the external ALU for one cycle. It captures the ALU result and writes it back
// to the register file. It then holds the response until the consumer accepts it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_op                   ALU opcode (0..12 legal, 13..15 illegal)
//   req_rd/rs1/rs2           destination / source register indices
//   req_imm_en, req_imm      select the immediate as operand B
//   resp_valid / resp_ready  response handshake
//   resp_data, resp_over, resp_under, resp_err   captured result and flags
//   alu_a, alu_b, alu_sel    operands and opcode driven to the external ALU
//   alu_out, alu_over, alu_under                 result returned by the ALU
//   clr_flags                clears the sticky overflow/underflow flags
//   ovf_sticky, unf_sticky   sticky flags
//   ops_done                 saturating count of response handshakes
//   dbg_addr, dbg_data       combinational register-file read port
module alu_seq_ctrl #(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_rd,
   input  logic [ADDR_W-1:0] req_rs1,
   input  logic [ADDR_W-1:0] req_rs2,
   input  logic              req_imm_en,
   input  logic [31:0]       req_imm,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic              resp_over,
   output logic              resp_under,
   output logic              resp_err,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [3:0]        alu_sel,
   input  logic [31:0]       alu_out,
   input  logic              alu_over,
   input  logic              alu_under,
   input  logic              clr_flags,
   output logic              ovf_sticky,
   output logic              unf_sticky,
   output logic [CNT_W-1:0]  ops_done,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_data
);

   // Opcode map: ADD SUB MUL AND OR XOR NOT EQ NEQ LT LTE GT GTE occupy 0..12.
   localparam logic [3:0] OP_LAST = 4'd12;
   localparam int         NREG    = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         a_q, a_d, b_q, b_d;
   logic [3:0]          op_q, op_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic                resp_over_q, resp_over_d;
   logic                resp_under_q, resp_under_d;
   logic                resp_err_q, resp_err_d;
   logic                resp_valid_q, resp_valid_d;
   logic                req_ready_q, req_ready_d;
   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic [CNT_W-1:0]    ops_q, ops_d;
   logic [31:0]         rf_q [NREG];
   logic                wr_en_s;
   logic                legal_s;

   assign legal_s = (op_q <= OP_LAST);

   // Next-state, operand latch, capture and counter logic.
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      rd_d         = rd_q;
      resp_data_d  = resp_data_q;
      resp_over_d  = resp_over_q;
      resp_under_d = resp_under_q;
      resp_err_d   = resp_err_q;
      resp_valid_d = resp_valid_q;
      req_ready_d  = req_ready_q;
      ops_d        = ops_q;
      wr_en_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               a_d         = rf_q[req_rs1];
               b_d         = req_imm_en ? req_imm : rf_q[req_rs2];
               op_d        = req_op;
               rd_d        = req_rd;
               req_ready_d = 1'b0;
               state_d     = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            // Illegal opcodes report an error with a cleared result and no writeback.
            if (legal_s) begin
               resp_data_d  = alu_out;
               resp_over_d  = alu_over;
               resp_under_d = alu_under;
               resp_err_d   = 1'b0;
               wr_en_s      = 1'b1;
            end else begin
               resp_data_d  = 32'd0;
               resp_over_d  = 1'b0;
               resp_under_d = 1'b0;
               resp_err_d   = 1'b1;
            end
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
               if (ops_q != {CNT_W{1'b1}}) begin
                  ops_d = ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  ops_d = ops_q;
               end
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
            state_d      = IDLE;
         end
      endcase
   end

   // Sticky flags: a capture that sets a flag wins over a coincident clear.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if ((state_q == EXEC) && legal_s && alu_over) begin
         ovf_d = 1'b1;
      end else if (clr_flags) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if ((state_q == EXEC) && legal_s && alu_under) begin
         unf_d = 1'b1;
      end else if (clr_flags) begin
         unf_d = 1'b0;
      end else begin
         unf_d = unf_q;
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         op_q         <= 4'd0;
         rd_q         <= {ADDR_W{1'b0}};
         resp_data_q  <= 32'd0;
         resp_over_q  <= 1'b0;
         resp_under_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         ops_q        <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         resp_data_q  <= resp_data_d;
         resp_over_q  <= resp_over_d;
         resp_under_q <= resp_under_d;
         resp_err_q   <= resp_err_d;
         resp_valid_q <= resp_valid_d;
         req_ready_q  <= req_ready_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         ops_q        <= ops_d;
      end
   end

   // Register file; the write lands before the next accept can read it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (wr_en_s) begin
         rf_q[rd_q] <= alu_out;
      end else begin
         rf_q[rd_q] <= rf_q[rd_q];
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_over  = resp_over_q;
   assign resp_under = resp_under_q;
   assign resp_err   = resp_err_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_sel    = op_q;
   assign ovf_sticky = ovf_q;
   assign unf_sticky = unf_q;
   assign ops_done   = ops_q;
   assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl. It plays the external ALU, keeps a transaction-level
// model of the register file and response, compares every cycle, and pins the
// model with hand-computed literal results.
module tb_alu_seq_ctrl;
   localparam int AW = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, req_valid, req_ready, req_imm_en;
   logic [3:0]    req_op;
   logic [AW-1:0] req_rd, req_rs1, req_rs2, dbg_addr;
   logic [31:0]   req_imm, resp_data, alu_a, alu_b, alu_out, dbg_data;
   logic          resp_valid, resp_ready, resp_over, resp_under, resp_err;
   logic [3:0]    alu_sel;
   logic          alu_over, alu_under, clr_flags, ovf_sticky, unf_sticky;
   logic [CW-1:0] ops_done;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_imm_en(req_imm_en), .req_imm(req_imm), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .resp_over(resp_over),
      .resp_under(resp_under), .resp_err(resp_err), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sel(alu_sel), .alu_out(alu_out), .alu_over(alu_over),
      .alu_under(alu_under), .clr_flags(clr_flags), .ovf_sticky(ovf_sticky),
      .unf_sticky(unf_sticky), .ops_done(ops_done), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data));

   // External ALU: signed arithmetic, over/under = result above/below 32-bit signed range.
   function automatic logic [33:0] alu_fn(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, r;
      logic [31:0] o;
      logic ov, un;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = 0; o = 32'd0; ov = 1'b0; un = 1'b0;
      case (sel)
         4'd0:  r = sa + sb;
         4'd1:  r = sa - sb;
         4'd2:  r = sa * sb;
         default: r = 0;
      endcase
      case (sel)
         4'd0, 4'd1, 4'd2: begin
            o = r[31:0];
            ov = (r > 64'sd2147483647);
            un = (r < -64'sd2147483648);
         end
         4'd3:  o = a & b;
         4'd4:  o = a | b;
         4'd5:  o = a ^ b;
         4'd6:  o = ~a;
         4'd7:  o = {31'd0, sa == sb};
         4'd8:  o = {31'd0, sa != sb};
         4'd9:  o = {31'd0, sa < sb};
         4'd10: o = {31'd0, sa <= sb};
         4'd11: o = {31'd0, sa > sb};
         4'd12: o = {31'd0, sa >= sb};
         default: o = 32'd0;
      endcase
      return {ov, un, o};
   endfunction

   always_comb {alu_over, alu_under, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] m_rf [8];
   logic [31:0] m_a, m_b, m_d;
   logic [3:0]  m_op;
   logic [2:0]  m_rd;
   logic        m_exec, m_valid, m_o, m_u, m_e, m_ovf, m_unf, m_init = 1'b0;
   int          m_ops;

   initial begin
      logic [33:0] r;
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
            m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_d = 0;
            m_o = 0; m_u = 0; m_e = 0; m_ovf = 0; m_unf = 0;
            m_exec = 0; m_valid = 0; m_ops = 0; m_init = 1'b1;
         end else if (m_init) begin
            if (m_exec) begin
               r = alu_fn(m_op, m_a, m_b);
               if (m_op <= 4'd12) begin
                  m_rf[m_rd] = r[31:0];
                  m_d = r[31:0]; m_o = r[33]; m_u = r[32]; m_e = 1'b0;
               end else begin
                  m_d = 32'd0; m_o = 1'b0; m_u = 1'b0; m_e = 1'b1;
               end
               m_ovf = m_o ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
               m_unf = m_u ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
               m_exec = 1'b0;
               m_valid = 1'b1;
            end else begin
               if (clr_flags) begin m_ovf = 1'b0; m_unf = 1'b0; end
               if (m_valid) begin
                  if (resp_ready) begin
                     m_valid = 1'b0;
                     if (m_ops < 65535) m_ops++;
                  end
               end else if (req_valid) begin
                  m_a = m_rf[req_rs1];
                  m_b = req_imm_en ? req_imm : m_rf[req_rs2];
                  m_op = req_op; m_rd = req_rd; m_exec = 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_init) begin
            chk("req_ready", 64'(req_ready), 64'(!m_exec && !m_valid));
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            chk("alu_a", 64'(alu_a), 64'(m_a));
            chk("alu_b", 64'(alu_b), 64'(m_b));
            chk("alu_sel", 64'(alu_sel), 64'(m_op));
            chk("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
            chk("unf_sticky", 64'(unf_sticky), 64'(m_unf));
            chk("ops_done", 64'(ops_done), 64'(m_ops));
            chk("dbg_data", 64'(dbg_data), 64'(m_rf[dbg_addr]));
            if (m_valid) begin
               chk("resp_data", 64'(resp_data), 64'(m_d));
               chk("resp_over", 64'(resp_over), 64'(m_o));
               chk("resp_under", 64'(resp_under), 64'(m_u));
               chk("resp_err", 64'(resp_err), 64'(m_e));
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin step(); n++; end
      if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic wait_resp();
      int n = 0;
      while (!resp_valid && n < 20) begin step(); n++; end
      if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
   endtask

   task automatic drive_req(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic ie, input logic [31:0] imm);
      req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_imm_en = ie; req_imm = imm; dbg_addr = rd;
      req_valid = 1'b1;
   endtask

   task automatic do_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [31:0] imm,
                        output logic [31:0] d, output logic e);
      drive_req(op, rd, rs1, rs2, ie, imm);
      wait_ready();
      step();
      req_valid = 1'b0;
      wait_resp();
      d = resp_data; e = resp_err;
      wait_ready();
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2;
      logic        ie;
      logic [31:0] imm, exp;
   } vec_t;

   vec_t vt [16] = '{
      '{4'd0,  3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{4'd0,  3'd2, 3'd1, 3'd0, 1'b1, 32'h00000001, 32'h80000000},
      '{4'd0,  3'd1, 3'd2, 3'd0, 1'b1, 32'h00000000, 32'h80000000},
      '{4'd1,  3'd2, 3'd1, 3'd0, 1'b1, 32'h00000001, 32'h7FFFFFFF},
      '{4'd2,  3'd5, 3'd2, 3'd0, 1'b1, 32'h00000003, 32'h7FFFFFFD},
      '{4'd5,  3'd3, 3'd5, 3'd2, 1'b0, 32'h0,        32'h00000002},
      '{4'd3,  3'd6, 3'd5, 3'd2, 1'b0, 32'h0,        32'h7FFFFFFD},
      '{4'd4,  3'd7, 3'd1, 3'd3, 1'b0, 32'h0,        32'h80000002},
      '{4'd6,  3'd6, 3'd6, 3'd0, 1'b0, 32'h0,        32'h80000002},
      '{4'd7,  3'd4, 3'd6, 3'd7, 1'b0, 32'h0,        32'h00000001},
      '{4'd8,  3'd4, 3'd6, 3'd7, 1'b0, 32'h0,        32'h00000000},
      '{4'd9,  3'd4, 3'd1, 3'd2, 1'b0, 32'h0,        32'h00000001},
      '{4'd10, 3'd4, 3'd2, 3'd2, 1'b0, 32'h0,        32'h00000001},
      '{4'd11, 3'd4, 3'd1, 3'd2, 1'b0, 32'h0,        32'h00000000},
      '{4'd12, 3'd4, 3'd2, 3'd1, 1'b0, 32'h0,        32'h00000001},
      '{4'd15, 3'd3, 3'd5, 3'd2, 1'b0, 32'h0,        32'h00000000}
   };

   initial begin
      logic [31:0] d, held;
      logic        e;
      rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_rd = 3'd0; req_rs1 = 3'd0;
      req_rs2 = 3'd0; req_imm_en = 1'b0; req_imm = 32'd0; resp_ready = 1'b1;
      clr_flags = 1'b0; dbg_addr = 3'd0;
      repeat (2) step();
      rst = 1'b0;
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_resp_valid", 64'(resp_valid), 64'd0);
      chk("reset_ops_done", 64'(ops_done), 64'd0);
      chk("reset_alu_a", 64'(alu_a), 64'd0);

      // Directed vector table, including read-after-write and rd==rs cases.
      for (int i = 0; i < 16; i++) begin
         do_op(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].ie, vt[i].imm, d, e);
         chk($sformatf("vec%0d_data", i), 64'(d), 64'(vt[i].exp));
         chk($sformatf("vec%0d_err", i), 64'(e), 64'(vt[i].op > 4'd12));
         if (i == 1) begin
            chk("add_ovf_sticky", 64'(ovf_sticky), 64'd1);
            chk("add_rf2", 64'(dbg_data), 64'h80000000);
         end
         if (i == 3) chk("sub_unf_sticky", 64'(unf_sticky), 64'd1);
      end
      dbg_addr = 3'd3; #1;
      chk("illegal_rf3_unchanged", 64'(dbg_data), 64'h2);

      // Backpressure: response held for 5 cycles while a second request waits.
      resp_ready = 1'b0;
      drive_req(4'd0, 3'd4, 3'd2, 3'd0, 1'b1, 32'h1);
      wait_ready();
      step();
      drive_req(4'd4, 3'd5, 3'd4, 3'd0, 1'b0, 32'h0);
      wait_resp();
      held = resp_data;
      chk("bp_data", 64'(held), 64'h80000000);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_valid_held", 64'(resp_valid), 64'd1);
         chk("bp_data_held", 64'(resp_data), 64'(held));
         chk("bp_not_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      step();
      chk("bp_ready_after_hs", 64'(req_ready), 64'd1);
      step();
      chk("bp_second_accepted", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      wait_resp();
      chk("bp_second_data", 64'(resp_data), 64'h80000000);
      wait_ready();
      chk("ops_done_count", 64'(ops_done), 64'd18);

      // Reset while the operation is in EXEC aborts it.
      drive_req(4'd0, 3'd4, 3'd2, 3'd0, 1'b1, 32'h5);
      wait_ready();
      step();
      rst = 1'b1; req_valid = 1'b0;
      step();
      rst = 1'b0;
      chk("abort_rf4", 64'(dbg_data), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("abort_no_resp", 64'(resp_valid), 64'd0);
      end
      chk("abort_ops_done", 64'(ops_done), 64'd0);

      // Clear coincident with an overflowing capture: set wins.
      do_op(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF, d, e);
      drive_req(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 32'h1);
      wait_ready();
      step();
      req_valid = 1'b0; clr_flags = 1'b1;
      step();
      chk("clr_set_wins", 64'(ovf_sticky), 64'd1);
      step();
      chk("clr_alone", 64'(ovf_sticky), 64'd0);
      clr_flags = 1'b0;
      wait_ready();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
